// File: rtl/vpu_exec_ctrl.sv
// vpu_exec_ctrl: command queue and one-in-flight scheduler for the VPU exec unit.
// Optional watchdog on exec done is enabled by defining VPU_EXEC_TIMEOUT_EN.
module vpu_exec_ctrl #(
    parameter int DWIDTH      = 256,
    parameter int SRC_CNT     = 3,
    parameter int OP_W        = 8,
    parameter int DELAY_LG2   = 4,
    parameter int CMDQ_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [OP_W-1:0]      cmd_op_i,
    input  logic [DELAY_LG2-1:0] cmd_delay_i,
    input  logic [SRC_CNT-1:0]   cmd_src_mask_i,
    input  logic [SRC_CNT-1:0]   opnd_valid_i,
    output logic [SRC_CNT-1:0]   opnd_pop_o,
    output logic                 exec_start_o,
    output logic [OP_W-1:0]      exec_op_o,
    output logic [DELAY_LG2-1:0] exec_delay_o,
    output logic [SRC_CNT-1:0]   exec_opnd_valid_o,
    input  logic                 exec_done_i,
    input  logic [DWIDTH-1:0]    exec_dout_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [DWIDTH-1:0]    res_data_o,
    output logic                 res_err_o,
    output logic                 busy_o
);
    localparam int AW = $clog2(CMDQ_DEPTH);
    localparam int EW = OP_W + DELAY_LG2 + SRC_CNT;

    typedef enum logic [2:0] {IDLE, WAIT_OPND, ISSUE, EXEC, RESP} state_t;

    state_t             state, state_nx;
    logic [EW-1:0]      q_mem [CMDQ_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count, count_nx;
    logic [EW-1:0]      cur;
    logic [SRC_CNT-1:0] cur_mask;
    logic               push, pop, exec_end, timeout, ready_q;
    logic [DWIDTH-1:0]  res_data;

    assign {exec_op_o, exec_delay_o, cur_mask} = cur;
    assign push              = cmd_valid_i && ready_q;
    assign count_nx          = count + (AW+1)'(push) - (AW+1)'(pop);
    assign exec_end          = state == EXEC && (exec_done_i || timeout);
    assign cmd_ready_o       = ready_q;
    assign exec_start_o      = state == ISSUE;
    assign exec_opnd_valid_o = (state == ISSUE || state == EXEC) ? cur_mask : '0;
    assign opnd_pop_o        = exec_end ? cur_mask : '0;
    assign res_valid_o       = state == RESP;
    assign res_data_o        = res_data;
    assign busy_o            = state != IDLE || count != '0;

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                pop      = count != '0;
                state_nx = pop ? WAIT_OPND : IDLE;
            end
            WAIT_OPND: state_nx = (opnd_valid_i & cur_mask) == cur_mask ? ISSUE : WAIT_OPND;
            ISSUE:     state_nx = EXEC;
            EXEC:      state_nx = exec_end ? RESP : EXEC;
            RESP: begin
                pop      = res_ready_i && count != '0;
                state_nx = !res_ready_i ? RESP : (pop ? WAIT_OPND : IDLE);
            end
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (push)
            q_mem[wr_ptr] <= {cmd_op_i, cmd_delay_i, cmd_src_mask_i};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_q  <= 1'b1;
            cur      <= '0;
            res_data <= '0;
        end else begin
            state   <= state_nx;
            count   <= count_nx;
            ready_q <= count_nx != (AW+1)'(CMDQ_DEPTH);
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                cur    <= q_mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            // a watchdog abort returns zero data
            if (exec_end)
                res_data <= exec_done_i ? exec_dout_i : '0;
        end
    end

`ifdef VPU_EXEC_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [TW-1:0] wdog;
    logic          res_err;

    assign timeout   = state == EXEC && !exec_done_i && wdog == TW'(TIMEOUT_CYC - 1);
    assign res_err_o = res_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog    <= '0;
            res_err <= 1'b0;
        end else begin
            wdog <= state == ISSUE ? '0 : (state == EXEC ? wdog + TW'(1) : wdog);
            if (exec_end)
                res_err <= timeout;
        end
    end
`else
    assign timeout   = 1'b0;
    assign res_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_vpu_exec_ctrl.sv
// tb_vpu_exec_ctrl: directed latency/backpressure scenarios plus randomized traffic
// against a transaction-order scoreboard and a simple exec-unit model.
module tb_vpu_exec_ctrl;
    localparam int DW = 256;
    localparam int SC = 3;
    localparam int OW = 8;
    localparam int DL = 4;
    localparam int EW = OW + DL + SC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [OW-1:0] cmd_op_i = '0;
    logic [DL-1:0] cmd_delay_i = '0;
    logic [SC-1:0] cmd_src_mask_i = '0;
    logic [SC-1:0] opnd_valid_i = '0;
    logic [SC-1:0] opnd_pop_o;
    logic          exec_start_o;
    logic [OW-1:0] exec_op_o;
    logic [DL-1:0] exec_delay_o;
    logic [SC-1:0] exec_opnd_valid_o;
    logic          exec_done_i = 1'b0;
    logic [DW-1:0] exec_dout_i = '0;
    logic          res_valid_o;
    logic          res_ready_i = 1'b0;
    logic [DW-1:0] res_data_o;
    logic          res_err_o;
    logic          busy_o;

    vpu_exec_ctrl #(.DWIDTH(DW), .SRC_CNT(SC), .OP_W(OW), .DELAY_LG2(DL),
                    .CMDQ_DEPTH(4), .TIMEOUT_CYC(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_delay_i(cmd_delay_i), .cmd_src_mask_i(cmd_src_mask_i),
        .opnd_valid_i(opnd_valid_i), .opnd_pop_o(opnd_pop_o),
        .exec_start_o(exec_start_o), .exec_op_o(exec_op_o), .exec_delay_o(exec_delay_o),
        .exec_opnd_valid_o(exec_opnd_valid_o), .exec_done_i(exec_done_i),
        .exec_dout_i(exec_dout_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_data_o(res_data_o), .res_err_o(res_err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    int n_acc = 0, n_start = 0, n_res = 0, start_cyc = -1, pop_cyc = -1;
    int em_cnt = -1, em_lat = 2;
    bit em_on = 1'b1, mon_on = 1'b0, tmo_mode = 1'b0, inflight = 1'b0;
    logic [DW-1:0] em_dout = '0, em_cur = '0;
    logic [SC-1:0] fl_mask = '0, prev_opnd = '0, exp_pop;
    logic [EW-1:0] sb_cmd[$];
    logic [DW-1:0] sb_res[$];

    // One clock: score the current cycle, advance, then let the exec model react.
    task automatic cycle();
        logic [EW-1:0] e;
        #1;
        if (mon_on) begin
            if (cmd_valid_i && cmd_ready_o) begin
                sb_cmd.push_back({cmd_op_i, cmd_delay_i, cmd_src_mask_i});
                n_acc++;
            end
            if (exec_start_o) begin
                n_start++;
                start_cyc = cyc;
                checks++;
                if (sb_cmd.size() == 0) begin
                    errors++;
                    $display("FAIL start_order: start with no queued command at cycle %0d", cyc);
                end else begin
                    e = sb_cmd.pop_front();
                    if ({exec_op_o, exec_delay_o, exec_opnd_valid_o} !== e ||
                        (prev_opnd & e[SC-1:0]) != e[SC-1:0]) begin
                        errors++;
                        $display("FAIL start_order: got op=%h dly=%h ov=%b prev_opnd=%b, want %h",
                                 exec_op_o, exec_delay_o, exec_opnd_valid_o, prev_opnd, e);
                    end
                    fl_mask  = e[SC-1:0];
                    inflight = 1'b1;
                    em_cnt   = em_on ? em_lat : -1;
                    em_cur   = em_dout;
                end
            end
            if (!tmo_mode) begin
                exp_pop = (inflight && exec_done_i && !exec_start_o) ? fl_mask : '0;
                checks++;
                if (opnd_pop_o !== exp_pop) begin
                    errors++;
                    $display("FAIL opnd_pop: got %b want %b at cycle %0d", opnd_pop_o, exp_pop, cyc);
                end
                if (inflight && exec_done_i && !exec_start_o) begin
                    sb_res.push_back(exec_dout_i);
                    inflight = 1'b0;
                    pop_cyc  = cyc;
                end
                if (res_valid_o && res_ready_i) begin
                    checks++;
                    n_res++;
                    if (sb_res.size() == 0) begin
                        errors++;
                        $display("FAIL result: unexpected result %h", res_data_o);
                    end else if (res_data_o !== sb_res[0] || res_err_o !== 1'b0) begin
                        errors++;
                        $display("FAIL result: got %h err=%b want %h err=0",
                                 res_data_o, res_err_o, sb_res[0]);
                        void'(sb_res.pop_front());
                    end else
                        void'(sb_res.pop_front());
                end
            end
        end
        prev_opnd = opnd_valid_i;
        @(posedge clk);
        #1;
        cyc++;
        exec_done_i = 1'b0;
        if (em_cnt > 0) begin
            em_cnt--;
            if (em_cnt == 0) begin
                exec_done_i = 1'b1;
                exec_dout_i = em_cur;
                em_cnt      = -1;
            end
        end
        #1;
    endtask

    task automatic push_cmd(input logic [OW-1:0] op, input logic [DL-1:0] dly,
                            input logic [SC-1:0] m, output int c);
        int n = 0;
        cmd_op_i = op; cmd_delay_i = dly; cmd_src_mask_i = m; cmd_valid_i = 1'b1;
        while (!cmd_ready_o && n < 50) begin cycle(); n++; end
        if (n == 50) begin errors++; $display("FAIL push_timeout: cmd_ready_o stuck low"); end
        c = cyc;
        cycle();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_res(input string name);
        int n = 0;
        while (!res_valid_o && n < 60) begin cycle(); n++; end
        checks++;
        if (!res_valid_o) begin errors++; $display("FAIL %s: res_valid_o=0 want 1 (timeout)", name); end
    endtask

    task automatic drain();
        int n = 0;
        cmd_valid_i = 1'b0; opnd_valid_i = '1; res_ready_i = 1'b1;
        while ((busy_o || sb_cmd.size() != 0 || sb_res.size() != 0 || inflight) && n < 500) begin
            cycle(); n++;
        end
        res_ready_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || sb_cmd.size() != 0 || sb_res.size() != 0 || inflight) begin
            errors++;
            $display("FAIL drain: busy=%b cmds_left=%0d res_left=%0d want all idle",
                     busy_o, sb_cmd.size(), sb_res.size());
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({cmd_ready_o, busy_o, exec_start_o, res_valid_o, res_err_o} !== 5'b10000 ||
            {opnd_pop_o, exec_opnd_valid_o, exec_op_o, exec_delay_o} !== '0 || res_data_o !== '0) begin
            errors++;
            $display("FAIL %s: rdy=%b busy=%b start=%b rv=%b err=%b pop=%b ov=%b op=%h dly=%h data=%h want rdy=1 rest 0",
                     name, cmd_ready_o, busy_o, exec_start_o, res_valid_o, res_err_o,
                     opnd_pop_o, exec_opnd_valid_o, exec_op_o, exec_delay_o, res_data_o);
        end
    endtask

    task automatic test_reset();
        mon_on = 1'b0; rst_n = 1'b0;
        repeat (3) cycle();
        check_idle_outputs("reset_state");
        rst_n = 1'b1; mon_on = 1'b1;
        cycle();
        check_idle_outputs("reset_release_idle");
    endtask

    task automatic test_single();
        int c0, rv;
        opnd_valid_i = 3'b011; res_ready_i = 1'b0;
        em_on = 1'b1; em_lat = 4; em_dout = {32{8'hA5}};
        push_cmd(8'h01, 4'd3, 3'b011, c0);
        wait_res("single_res");
        rv = cyc;
        checks++;
        if (start_cyc != c0 + 3) begin errors++; $display("FAIL single_start: cycle %0d want %0d", start_cyc - c0, 3); end
        checks++;
        if (pop_cyc != c0 + 7) begin errors++; $display("FAIL single_pop: cycle %0d want %0d", pop_cyc - c0, 7); end
        checks++;
        if (rv != c0 + 8 || res_data_o !== {32{8'hA5}}) begin
            errors++;
            $display("FAIL single_res: cycle %0d data %h want cycle 8 data a5..", rv - c0, res_data_o);
        end
        res_ready_i = 1'b1;
        cycle();
        res_ready_i = 1'b0;
        cycle();
        checks++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL single_done: rv=%b busy=%b want 0 0", res_valid_o, busy_o);
        end
    endtask

    task automatic test_queue_full();
        int a0, s0, n, seen;
        opnd_valid_i = '0; res_ready_i = 1'b1; em_on = 1'b1; em_lat = 2;
        a0 = n_acc; s0 = n_start;
        cmd_valid_i = 1'b1;
        cmd_op_i = 8'($urandom); cmd_delay_i = 4'($urandom); cmd_src_mask_i = 3'($urandom_range(1, 7));
        repeat (12) begin
            seen = n_acc;
            cycle();
            if (n_acc != seen) begin
                cmd_op_i = 8'($urandom); cmd_delay_i = 4'($urandom); cmd_src_mask_i = 3'($urandom_range(1, 7));
            end
        end
        checks++;
        if (n_acc - a0 != 5 || cmd_ready_o !== 1'b0 || n_start != s0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL queue_full: accepted=%0d rdy=%b starts=%0d busy=%b want 5 0 0 1",
                     n_acc - a0, cmd_ready_o, n_start - s0, busy_o);
        end
        opnd_valid_i = '1;
        n = 0;
        while (n_acc - a0 < 6 && n < 40) begin cycle(); n++; end
        checks++;
        if (n_acc - a0 != 6 || n_start == s0) begin
            errors++;
            $display("FAIL queue_sixth: accepted=%0d starts_before=%0d want 6 and >=1", n_acc - a0, n_start - s0);
        end
        drain();
    endtask

    task automatic test_starve();
        int c0, s0, v;
        opnd_valid_i = 3'b100; em_on = 1'b1; em_lat = 3; em_dout = {8{$urandom}};
        push_cmd(8'h5A, 4'd0, 3'b111, c0);
        cycle();
        s0 = n_start;
        repeat (10) cycle();
        checks++;
        if (n_start != s0) begin errors++; $display("FAIL starve_hold: %0d starts want 0", n_start - s0); end
        opnd_valid_i = 3'b111;
        v = cyc;
        cycle();
        cycle();
        checks++;
        if (n_start != s0 + 1 || start_cyc != v + 1) begin
            errors++;
            $display("FAIL starve_start: starts=%0d at +%0d want 1 at +1", n_start - s0, start_cyc - v);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int c, s1, h;
        logic [DW-1:0] d0;
        bit bad = 1'b0;
        opnd_valid_i = '1; res_ready_i = 1'b0; em_on = 1'b1; em_lat = 2; em_dout = {8{$urandom}};
        push_cmd(8'hC3, 4'd7, 3'b101, c);
        em_dout = {8{$urandom}};
        push_cmd(8'h3C, 4'd2, 3'b010, c);
        wait_res("bp_res");
        s1 = n_start;
        d0 = res_data_o;
        repeat (6) begin
            cycle();
            if (res_valid_o !== 1'b1 || res_data_o !== d0) bad = 1'b1;
        end
        checks++;
        if (bad || n_start != s1) begin
            errors++;
            $display("FAIL bp_hold: rv=%b data=%h starts=%0d want 1 %h 0", res_valid_o, res_data_o, n_start - s1, d0);
        end
        res_ready_i = 1'b1;
        h = cyc;
        cycle();
        res_ready_i = 1'b0;
        repeat (3) cycle();
        checks++;
        if (n_start != s1 + 1 || start_cyc != h + 2) begin
            errors++;
            $display("FAIL bp_second: starts=%0d at +%0d want 1 at +2", n_start - s1, start_cyc - h);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int c, s0, r0, n = 0;
        bit bad = 1'b0;
        opnd_valid_i = '1; res_ready_i = 1'b1; em_on = 1'b0;
        push_cmd(8'h11, 4'd1, 3'b001, c);
        push_cmd(8'h22, 4'd2, 3'b010, c);
        push_cmd(8'h33, 4'd3, 3'b100, c);
        while (n_start == 0 && n < 40) begin cycle(); n++; end
        if (n_start == 0) begin
            while (start_cyc < 0 && n < 40) begin cycle(); n++; end
        end
        cycle();
        rst_n = 1'b0;
        cycle();
        check_idle_outputs("reset_mid");
        sb_cmd.delete(); sb_res.delete(); inflight = 1'b0; em_cnt = -1;
        rst_n = 1'b1;
        exec_done_i = 1'b1;
        s0 = n_start; r0 = n_res;
        repeat (10) begin
            cycle();
            if (res_valid_o !== 1'b0 || exec_start_o !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || n_start != s0 || n_res != r0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_late_done: rv=%b starts=%0d results=%0d busy=%b want all 0",
                     res_valid_o, n_start - s0, n_res - r0, busy_o);
        end
        em_on = 1'b1;
    endtask

    task automatic test_random();
        int a0, r0, seen;
        a0 = n_acc; r0 = n_res;
        em_on = 1'b1;
        cmd_op_i = 8'($urandom); cmd_delay_i = 4'($urandom); cmd_src_mask_i = 3'($urandom);
        repeat (600) begin
            cmd_valid_i  = ($urandom_range(0, 2) != 0);
            opnd_valid_i = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            res_ready_i  = ($urandom_range(0, 9) < 7);
            em_lat       = $urandom_range(1, 6);
            em_dout      = {8{$urandom}};
            seen = n_acc;
            cycle();
            if (n_acc != seen) begin
                cmd_op_i = 8'($urandom); cmd_delay_i = 4'($urandom); cmd_src_mask_i = 3'($urandom);
            end
        end
        drain();
        checks++;
        if (n_res - r0 != n_acc - a0 || n_acc - a0 < 20) begin
            errors++;
            $display("FAIL random_count: results=%0d accepted=%0d want equal and >=20", n_res - r0, n_acc - a0);
        end
    endtask

`ifdef VPU_EXEC_TIMEOUT_EN
    task automatic test_timeout();
        int c, s, n = 0;
        em_on = 1'b0; tmo_mode = 1'b1; opnd_valid_i = '1; res_ready_i = 1'b0;
        s = n_start;
        push_cmd(8'h77, 4'd5, 3'b011, c);
        while (n_start == s && n < 40) begin cycle(); n++; end
        s = start_cyc;
        while (cyc < s + 20 && n < 100) begin cycle(); n++; end
        checks++;
        if (opnd_pop_o !== 3'b011 || res_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pop: pop=%b rv=%b want 011 0", opnd_pop_o, res_valid_o);
        end
        cycle();
        checks++;
        if (res_valid_o !== 1'b1 || res_err_o !== 1'b1 || res_data_o !== '0) begin
            errors++;
            $display("FAIL timeout_res: rv=%b err=%b data=%h want 1 1 0", res_valid_o, res_err_o, res_data_o);
        end
        res_ready_i = 1'b1;
        cycle();
        res_ready_i = 1'b0;
        tmo_mode = 1'b0; inflight = 1'b0; em_on = 1'b1;
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_queue_full();
        test_starve();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef VPU_EXEC_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
